mem_arbiter: RTL

- Shares one single-port, fixed-latency unified memory between the pipeline's IF stage (instruction fetch) and MA stage (load/store).
- Serialises requests, sequences each access through a latency counter, and returns a one-cycle ack with read data.
- Drives stall outputs that the core uses to freeze IF or MA while their access is pending.

---
 rtl/mem_arbiter_pkg.sv | 21 ++
 rtl/mem_arb_sel.sv | 37 +++
 rtl/mem_arbiter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the IF/MA unified-memory arbiter.
package mem_arbiter_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_WAIT = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_MA = 1'b1
  } port_e;

  function automatic port_e other_port(input port_e p);
    other_port = (p == PORT_IF) ? PORT_MA : PORT_IF;
  endfunction

endpackage

// File: rtl/mem_arb_sel.sv
// Combinational grant select. MEM_ARB_FAIR_EN: alternate the winner on contention
// (opposite to last_grant); otherwise MA always wins.
module mem_arb_sel
  import mem_arbiter_pkg::*;
(
  input  logic  if_req_i,
  input  logic  ma_req_i,
  input  port_e last_grant_i,
  output port_e gnt_o
);

`ifndef MEM_ARB_FAIR_EN
  logic unused_last_grant_s;
  assign unused_last_grant_s = last_grant_i;
`endif

  // Pick the port to serve when the arbiter is idle.
  always_comb begin
    gnt_o = PORT_IF;
`ifdef MEM_ARB_FAIR_EN
    if (if_req_i && ma_req_i) begin
      gnt_o = other_port(last_grant_i);
    end else if (ma_req_i) begin
      gnt_o = PORT_MA;
    end else begin
      gnt_o = PORT_IF;
    end
`else
    if (ma_req_i) begin
      gnt_o = PORT_MA;
    end else begin
      gnt_o = PORT_IF;
    end
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one fixed-latency single-port memory between IF and MA stages.
// Optional MEM_ARB_FAIR_EN builds last_grant and enables alternating priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW      = XLEN,
  parameter int DW      = XLEN,
  parameter int MEM_LAT = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            if_req_i,
  input  logic [AW-1:0]   if_addr_i,
  output logic            if_ack_o,
  output logic [DW-1:0]   if_rdata_o,
  input  logic            ma_req_i,
  input  logic            ma_we_i,
  input  logic [DW/8-1:0] ma_be_i,
  input  logic [AW-1:0]   ma_addr_i,
  input  logic [DW-1:0]   ma_wdata_i,
  output logic            ma_ack_o,
  output logic [DW-1:0]   ma_rdata_o,
  output logic            stall_if_o,
  output logic            stall_ma_o,
  output logic            mem_en_o,
  output logic            mem_we_o,
  output logic [DW/8-1:0] mem_be_o,
  output logic [AW-1:0]   mem_addr_o,
  output logic [DW-1:0]   mem_wdata_o,
  input  logic [DW-1:0]   mem_rdata_i
);

  localparam int BW = DW / 8;
  localparam int CW = $clog2(MEM_LAT + 1);

  arb_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  port_e         gnt_q, gnt_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [BW-1:0] mem_be_q, mem_be_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          if_ack_q, if_ack_d;
  logic          ma_ack_q, ma_ack_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] ma_rdata_q, ma_rdata_d;
  port_e         last_grant_s;
  port_e         sel_gnt_s;

`ifdef MEM_ARB_FAIR_EN
  port_e last_grant_q, last_grant_d;
  assign last_grant_s = last_grant_q;
`else
  assign last_grant_s = PORT_IF;
`endif

  mem_arb_sel u_sel (
    .if_req_i     (if_req_i),
    .ma_req_i     (ma_req_i),
    .last_grant_i (last_grant_s),
    .gnt_o        (sel_gnt_s)
  );

  // Next-state and output logic of the access sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    mem_en_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    ma_ack_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    ma_rdata_d  = ma_rdata_q;
`ifdef MEM_ARB_FAIR_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (if_req_i || ma_req_i) begin
          gnt_d    = sel_gnt_s;
          mem_en_d = 1'b1;
          cnt_d    = CW'(MEM_LAT);
          state_d  = ARB_WAIT;
`ifdef MEM_ARB_FAIR_EN
          last_grant_d = sel_gnt_s;
`endif
          if (sel_gnt_s == PORT_MA) begin
            mem_we_d    = ma_we_i;
            mem_be_d    = ma_be_i;
            mem_addr_d  = ma_addr_i;
            mem_wdata_d = ma_wdata_i;
          end else begin
            mem_we_d    = 1'b0;
            mem_be_d    = {BW{1'b1}};
            mem_addr_d  = if_addr_i;
            mem_wdata_d = {DW{1'b0}};
          end
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_WAIT: begin
        // cnt reaches zero exactly in the cycle mem_rdata is valid
        if (cnt_q == {CW{1'b0}}) begin
          state_d = ARB_RESP;
          if (gnt_q == PORT_IF) begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata_i;
          end else begin
            ma_ack_d = 1'b1;
            if (!mem_we_q) begin
              ma_rdata_d = mem_rdata_i;
            end else begin
              ma_rdata_d = ma_rdata_q;
            end
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ARB_RESP: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ARB_IDLE;
      cnt_q       <= {CW{1'b0}};
      gnt_q       <= PORT_IF;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= {BW{1'b0}};
      mem_addr_q  <= {AW{1'b0}};
      mem_wdata_q <= {DW{1'b0}};
      if_ack_q    <= 1'b0;
      ma_ack_q    <= 1'b0;
      if_rdata_q  <= {DW{1'b0}};
      ma_rdata_q  <= {DW{1'b0}};
`ifdef MEM_ARB_FAIR_EN
      last_grant_q <= PORT_IF;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      ma_ack_q    <= ma_ack_d;
      if_rdata_q  <= if_rdata_d;
      ma_rdata_q  <= ma_rdata_d;
`ifdef MEM_ARB_FAIR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign if_ack_o    = if_ack_q;
  assign ma_ack_o    = ma_ack_q;
  assign if_rdata_o  = if_rdata_q;
  assign ma_rdata_o  = ma_rdata_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_be_o    = mem_be_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign stall_if_o  = if_req_i & ~if_ack_q;
  assign stall_ma_o  = ma_req_i & ~ma_ack_q;

endmodule
